schoolbook_operand_loader: RTL and testbench

//   Upstream feeder and sequencer for the 409x409 schoolbook multiplier.

---
 rtl/schoolbook_operand_loader_pkg.sv | 32 +++
 rtl/schoolbook_operand_loader_if.sv | 24 ++
 rtl/schoolbook_operand_loader.sv | 140 ++++++++++++++
 tb/tb_schoolbook_operand_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/schoolbook_operand_loader_pkg.sv
// Shared constants, state encoding and the word-placement helper for the
// schoolbook multiplier operand loader.
package schoolbook_pkg;

    localparam int N     = 409;
    localparam int W     = 32;
    localparam int NW    = (N + W - 1) / W;
    localparam int LAT   = N + 1;
    localparam int IDX_W = $clog2(NW);
    localparam int CNT_W = $clog2(LAT);
    localparam int SH_W  = $clog2(NW * W);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Writes one word into lane idx of an operand; bits that fall past N
    // (the top word's upper 7 bits) are shifted out and so discarded.
    function automatic logic [N-1:0] place_word(input logic [N-1:0]     cur,
                                                input logic [W-1:0]     word,
                                                input logic [IDX_W-1:0] idx);
        logic [SH_W-1:0] sh;
        logic [N-1:0]    lane;
        sh   = SH_W'(idx) * SH_W'(W);
        lane = {{(N-W){1'b0}}, {W{1'b1}}} << sh;
        return (cur & ~lane) | ({{(N-W){1'b0}}, word} << sh);
    endfunction

endpackage

// File: rtl/schoolbook_operand_loader_if.sv
// Word stream in, operands and multiplier sequencing out.
interface schoolbook_operand_loader_if;
    import schoolbook_pkg::*;

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         mul_rst;
    logic         busy;
    logic         done;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, op_a, op_b, mul_rst, busy, done
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, op_a, op_b, mul_rst, busy, done
    );
endinterface

// File: rtl/schoolbook_operand_loader.sv
// Assembles operands a and b from the word stream, then releases the
// multiplier's reset and times its fixed latency to flag done.
module schoolbook_operand_loader
    import schoolbook_pkg::*;
(
    input logic clk,
    input logic rst,
    schoolbook_operand_loader_if.slave bus
);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [N-1:0]     a_r, a_s;
    logic [N-1:0]     b_r, b_s;
    logic             mul_rst_r, mul_rst_s;
    logic             done_r, done_s;
    logic             ready_r, ready_s;
    logic             busy_r, busy_s;
    logic             accept_s;
    logic             last_s;

    // Next-state, operand writes and registered-output precomputation.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        a_s       = a_r;
        b_s       = b_r;
        mul_rst_s = mul_rst_r;
        done_s    = done_r;
        accept_s  = bus.in_valid & ready_r;
        last_s    = (idx_r == IDX_W'(NW - 1));

        if (bus.abort) begin
            // Abort wins over a simultaneous accept; operands are kept.
            state_s   = LOAD_A;
            idx_s     = '0;
            cnt_s     = '0;
            mul_rst_s = 1'b0;
            done_s    = 1'b0;
        end else begin
            case (state_r)
                LOAD_A: begin
                    if (accept_s) begin
                        a_s = place_word(a_r, bus.in_data, idx_r);
                        if (last_s) begin
                            state_s = LOAD_B;
                            idx_s   = '0;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                LOAD_B: begin
                    if (accept_s) begin
                        b_s = place_word(b_r, bus.in_data, idx_r);
                        if (last_s) begin
                            state_s   = RUN;
                            idx_s     = '0;
                            cnt_s     = '0;
                            mul_rst_s = 1'b1;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                RUN: begin
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(LAT - 1)) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end else begin
                        done_s = 1'b0;
                    end
                end
                DONE: begin
                    // Accepting here starts the next job with this word as a[0].
                    if (accept_s) begin
                        a_s       = place_word(a_r, bus.in_data, IDX_W'(0));
                        idx_s     = IDX_W'(1);
                        state_s   = LOAD_A;
                        mul_rst_s = 1'b0;
                        done_s    = 1'b0;
                    end else begin
                        done_s = 1'b1;
                    end
                end
                default: begin
                    state_s   = LOAD_A;
                    idx_s     = '0;
                    cnt_s     = '0;
                    mul_rst_s = 1'b0;
                    done_s    = 1'b0;
                end
            endcase
        end

        ready_s = (state_s != RUN);
        busy_s  = (state_s == LOAD_B) || (state_s == RUN) ||
                  ((state_s == LOAD_A) && (idx_s != '0));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= LOAD_A;
            idx_r     <= '0;
            cnt_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            mul_rst_r <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            a_r       <= a_s;
            b_r       <= b_s;
            mul_rst_r <= mul_rst_s;
            done_r    <= done_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.in_ready = ready_r;
    assign bus.op_a     = a_r;
    assign bus.op_b     = b_r;
    assign bus.mul_rst  = mul_rst_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_schoolbook_operand_loader.sv
// Scoreboard bench: random word streams, a bit-serial multiplier model driven
// by the loader, and a monitor that checks product and latency at done.
module tb_schoolbook_operand_loader;
    import schoolbook_pkg::*;

    localparam int CW = 2 * N;

    typedef struct {
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [CW-1:0] c;
    } job_t;

    typedef struct {
        string         name;
        logic [CW-1:0] act;
        logic [CW-1:0] exp;
    } dchk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    schoolbook_operand_loader_if bus();
    schoolbook_operand_loader dut (.clk(clk), .rst(rst), .bus(bus));

    job_t  exp_q[$];
    dchk_t dchk_q[$];
    int    errors = 0;
    int    checks = 0;

    logic [W-1:0] aw[NW];
    logic [W-1:0] bw[NW];

    // Stand-in for the 409x409 multiplier: one skip cycle, then one bit of b per cycle.
    logic [CW-1:0] mul_c = '0;
    int            mul_step = 0;
    always @(posedge clk) begin
        if (bus.mul_rst !== 1'b1) begin
            mul_step <= 0;
            mul_c    <= '0;
        end else if (mul_step == 0) begin
            mul_step <= 1;
        end else if (mul_step <= N) begin
            if (bus.op_b[mul_step-1])
                mul_c <= mul_c + (CW'(bus.op_a) << (mul_step - 1));
            mul_step <= mul_step + 1;
        end
    end

    function automatic logic [N-1:0] assemble(input logic [W-1:0] w[NW]);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++)
            v = v + (N'(w[i]) << (i * W));
        return v;
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dcheck(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dchk_q.push_back(d);
    endtask

    // Monitor: the only process that compares and counts.
    logic done_q = 1'b0;
    logic mul_rst_q = 1'b0;
    int   run_cycles = 0;
    bit   ready_leak = 1'b0;
    initial forever begin
        job_t  j;
        dchk_t d;
        @(negedge clk);
        while (dchk_q.size() > 0) begin
            d = dchk_q.pop_front();
            chk(d.name, d.act, d.exp);
        end
        if (bus.mul_rst === 1'b1 && mul_rst_q !== 1'b1) begin
            run_cycles = 0;
            ready_leak = 1'b0;
        end else if (bus.mul_rst === 1'b1) begin
            run_cycles++;
        end
        if (bus.mul_rst === 1'b1 && bus.done !== 1'b1 && bus.in_ready !== 1'b0)
            ready_leak = 1'b1;
        if (bus.done === 1'b1 && done_q !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", CW'(1), CW'(0));
            end else begin
                j = exp_q.pop_front();
                chk("op_a", CW'(bus.op_a), CW'(j.a));
                chk("op_b", CW'(bus.op_b), CW'(j.b));
                chk("product", mul_c, j.c);
                chk("latency", CW'(run_cycles), CW'(LAT));
                chk("ready_low_in_run", CW'(ready_leak), CW'(0));
            end
        end
        done_q    = bus.done;
        mul_rst_q = bus.mul_rst;
    end

    task automatic send_word(input logic [W-1:0] w, input int gap);
        bit acc;
        while (int'($urandom_range(99)) < gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 2000 && !acc; t++) begin
            acc = (bus.in_ready === 1'b1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) dcheck("accept_timeout", CW'(0), CW'(1));
    endtask

    task automatic run_job(input int gap, input bit push, input bit from_done);
        logic [N-1:0] a;
        logic [N-1:0] b;
        for (int i = 0; i < NW; i++) begin
            send_word(aw[i], gap);
            if (i == 0 && from_done) begin
                dcheck("mul_rst_fall_on_accept", CW'(bus.mul_rst), CW'(0));
                dcheck("done_fall_on_accept", CW'(bus.done), CW'(0));
                dcheck("busy_after_first", CW'(bus.busy), CW'(1));
            end
        end
        for (int i = 0; i < NW; i++) begin
            send_word(bw[i], gap);
            if (i == NW - 2) dcheck("mul_rst_before_last", CW'(bus.mul_rst), CW'(0));
        end
        dcheck("mul_rst_after_last", CW'(bus.mul_rst), CW'(1));
        dcheck("ready_in_run", CW'(bus.in_ready), CW'(0));
        dcheck("busy_in_run", CW'(bus.busy), CW'(1));
        a = assemble(aw);
        b = assemble(bw);
        if (push) exp_q.push_back('{a, b, CW'(a) * CW'(b)});
    endtask

    task automatic wait_done();
        for (int t = 0; t < LAT + 50; t++) begin
            if (bus.done === 1'b1) break;
            @(posedge clk); #1;
        end
        dcheck("done_timeout", CW'(bus.done), CW'(1));
    endtask

    task automatic randomize_words();
        for (int i = 0; i < NW; i++) begin
            aw[i] = $urandom();
            bw[i] = $urandom();
        end
    endtask

    task automatic check_reset_values(input string tag);
        dcheck({tag, "_op_a"}, CW'(bus.op_a), CW'(0));
        dcheck({tag, "_op_b"}, CW'(bus.op_b), CW'(0));
        dcheck({tag, "_mul_rst"}, CW'(bus.mul_rst), CW'(0));
        dcheck({tag, "_done"}, CW'(bus.done), CW'(0));
        dcheck({tag, "_busy"}, CW'(bus.busy), CW'(0));
        dcheck({tag, "_in_ready"}, CW'(bus.in_ready), CW'(1));
    endtask

    initial begin
        logic [N-1:0] a_keep;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        rst          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        rst = 1'b1;

        // a = 1, b = 1, no gaps
        for (int i = 0; i < NW; i++) begin
            aw[i] = '0;
            bw[i] = '0;
        end
        aw[0] = 32'd1;
        bw[0] = 32'd1;
        run_job(0, 1'b1, 1'b0);
        wait_done();

        // all-ones words: top word's upper bits must be dropped
        for (int i = 0; i < NW; i++) begin
            aw[i] = 32'hFFFF_FFFF;
            bw[i] = 32'hFFFF_FFFF;
        end
        run_job(0, 1'b1, 1'b1);
        wait_done();

        // random operands with input gaps, back-to-back from DONE
        for (int k = 0; k < 3; k++) begin
            randomize_words();
            run_job(30, 1'b1, 1'b1);
            wait_done();
            repeat ($urandom_range(5, 1)) begin
                @(posedge clk); #1;
                dcheck("done_held", CW'(bus.done), CW'(1));
            end
        end

        // abort in RUN with cnt = 200
        randomize_words();
        a_keep = assemble(aw);
        run_job(0, 1'b0, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        dcheck("abort_mul_rst", CW'(bus.mul_rst), CW'(0));
        dcheck("abort_done", CW'(bus.done), CW'(0));
        dcheck("abort_busy", CW'(bus.busy), CW'(0));
        dcheck("abort_in_ready", CW'(bus.in_ready), CW'(1));
        dcheck("abort_op_a_kept", CW'(bus.op_a), CW'(a_keep));
        repeat (LAT + 40) @(posedge clk);
        #1;

        // abort with a simultaneous word in LOAD_A: the word is dropped
        for (int i = 0; i < 3; i++) send_word($urandom(), 0);
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        dcheck("abort_accept_busy", CW'(bus.busy), CW'(0));
        randomize_words();
        run_job(20, 1'b1, 1'b0);
        wait_done();

        // rst in LOAD_B at idx 5
        randomize_words();
        for (int i = 0; i < NW; i++) send_word(aw[i], 0);
        for (int i = 0; i < 5; i++) send_word(bw[i], 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_reset_values("midrst");
        randomize_words();
        run_job(30, 1'b1, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL pending_jobs: got %0d expected 0", exp_q.size());
            errors++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
